// File: rtl/match_tally_pkg.sv
// Shared definitions for the match_tally block: default parameter values
// and the alarm FSM state encoding.
package match_tally_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_THRESH = 4;
  localparam int DEF_HOLD   = 3;

  // Code 2'b11 is never entered; the FSM steers it back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ALERT = 2'b01,
    ST_LOCK  = 2'b10
  } alarm_state_t;

endpackage

// File: rtl/match_tally_if.sv
// Bundle of the match flag input, soft clear and all tally outputs.
// The master side drives ans_in/clr; the slave side is the tally block.
interface match_tally_if #(
  parameter int CNT_W = 8
) ();

  logic             ans_in;
  logic             clr;
  logic             rise;
  logic [CNT_W-1:0] count;
  logic             sat;
  logic [CNT_W-1:0] dwell;
  logic             alarm;
  logic             locked;

  modport master (
    output ans_in, clr,
    input  rise, count, sat, dwell, alarm, locked
  );

  modport slave (
    input  ans_in, clr,
    output rise, count, sat, dwell, alarm, locked
  );

endinterface

// File: rtl/match_tally_edge_pulse.sv
// Turns the level match flag into a one-cycle rising-edge pulse.
// ans_q tracks ans_in on every non-reset edge, even while clr is asserted,
// so a flag that stays high across a clear never produces a new match.
module match_tally_edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic ans_in,
  output logic rise,
  output logic match
);

  logic ans_q_r;
  logic rise_r;
  logic match_s;

  // Combinational match: flag high now, low on the previous sample.
  always_comb begin
    match_s = ans_in & ~ans_q_r;
  end

  // Delay register for the flag and registered pulse output.
  always_ff @(posedge clk) begin
    if (reset) begin
      ans_q_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      ans_q_r <= ans_in;
      if (clr) begin
        rise_r <= 1'b0;
      end else begin
        rise_r <= match_s;
      end
    end
  end

  assign rise  = rise_r;
  assign match = match_s;

endmodule

// File: rtl/match_tally.sv
// Match tally: saturating match counter, dwell counter and a threshold
// alarm that stays up for HOLD cycles before latching into a lock state.
module match_tally
  import match_tally_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int THRESH = DEF_THRESH,
  parameter int HOLD   = DEF_HOLD
) (
  input  logic        clk,
  input  logic        reset,
  match_tally_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH_V  = CNT_W'(THRESH);
  localparam int               HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

  logic              rise_s;
  logic              match_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              count_inc_s;
  logic              thresh_hit_s;
  logic              sat_r;
  logic [CNT_W-1:0]  dwell_r;
  logic [CNT_W-1:0]  dwell_nxt_s;
  alarm_state_t      state_r;
  logic [HOLD_W-1:0] hold_r;
  logic              alarm_r;
  logic              locked_r;

  match_tally_edge_pulse u_edge (
    .clk    (clk),
    .reset  (reset),
    .clr    (bus.clr),
    .ans_in (bus.ans_in),
    .rise   (rise_s),
    .match  (match_s)
  );

  // Next match count (saturating) and detection of the threshold crossing.
  always_comb begin
    count_inc_s  = 1'b0;
    count_nxt_s  = count_r;
    thresh_hit_s = 1'b0;
    if (match_s && (count_r != CNT_MAX)) begin
      count_inc_s = 1'b1;
      count_nxt_s = count_r + CNT_ONE;
    end else begin
      count_inc_s = 1'b0;
      count_nxt_s = count_r;
    end
    thresh_hit_s = count_inc_s && (count_nxt_s == THRESH_V);
  end

  // Next dwell value: run length of sampled-high flag, saturating.
  always_comb begin
    dwell_nxt_s = dwell_r;
    if (bus.ans_in) begin
      if (dwell_r == CNT_MAX) begin
        dwell_nxt_s = dwell_r;
      end else begin
        dwell_nxt_s = dwell_r + CNT_ONE;
      end
    end else begin
      dwell_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Count, saturation flag and dwell registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
      sat_r   <= 1'b0;
      dwell_r <= {CNT_W{1'b0}};
    end else if (bus.clr) begin
      count_r <= {CNT_W{1'b0}};
      sat_r   <= 1'b0;
      dwell_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
      sat_r   <= (count_nxt_s == CNT_MAX);
      dwell_r <= dwell_nxt_s;
    end
  end

  // Alarm FSM with registered alarm/locked outputs and hold countdown.
  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      state_r  <= ST_IDLE;
      hold_r   <= HOLD_ZERO;
      alarm_r  <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (thresh_hit_s) begin
            state_r  <= ST_ALERT;
            hold_r   <= HOLD_INIT;
            alarm_r  <= 1'b1;
            locked_r <= 1'b0;
          end else begin
            state_r  <= ST_IDLE;
            hold_r   <= HOLD_ZERO;
            alarm_r  <= 1'b0;
            locked_r <= 1'b0;
          end
        end
        ST_ALERT: begin
          if (hold_r == HOLD_ZERO) begin
            state_r  <= ST_LOCK;
            hold_r   <= HOLD_ZERO;
            alarm_r  <= 1'b0;
            locked_r <= 1'b1;
          end else begin
            state_r  <= ST_ALERT;
            hold_r   <= hold_r - HOLD_ONE;
            alarm_r  <= 1'b1;
            locked_r <= 1'b0;
          end
        end
        ST_LOCK: begin
          state_r  <= ST_LOCK;
          hold_r   <= HOLD_ZERO;
          alarm_r  <= 1'b0;
          locked_r <= 1'b1;
        end
        default: begin
          state_r  <= ST_IDLE;
          hold_r   <= HOLD_ZERO;
          alarm_r  <= 1'b0;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rise   = rise_s;
  assign bus.count  = count_r;
  assign bus.sat    = sat_r;
  assign bus.dwell  = dwell_r;
  assign bus.alarm  = alarm_r;
  assign bus.locked = locked_r;

endmodule

// File: tb/tb_match_tally.sv
// Scoreboard bench for match_tally. Two instances run on the same stimulus:
// A (CNT_W=8, THRESH=4, HOLD=3) and B (CNT_W=3, THRESH=4, HOLD=1).
// A behavioural model counts matches and run lengths as plain integers and
// derives the alarm from "cycles since the threshold was crossed".
module tb_match_tally;

  typedef struct packed {
    logic       rise;
    logic [7:0] count;
    logic       sat;
    logic [7:0] dwell;
    logic       alarm;
    logic       locked;
  } exp_t;

  logic clk;
  logic reset;
  logic ans;
  logic clr;

  int tests;
  int fails;
  int cyc;

  exp_t qa[$];
  exp_t qb[$];

  // model state per instance
  int m_prev[2];
  int m_matches[2];
  int m_run[2];
  int m_since[2];
  int m_rise[2];

  match_tally_if #(.CNT_W(8)) bus_a ();
  match_tally_if #(.CNT_W(3)) bus_b ();

  assign bus_a.ans_in = ans;
  assign bus_a.clr    = clr;
  assign bus_b.ans_in = ans;
  assign bus_b.clr    = clr;

  match_tally #(.CNT_W(8), .THRESH(4), .HOLD(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  match_tally #(.CNT_W(3), .THRESH(4), .HOLD(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic exp_t model_step(int id, int maxv, int thr, int hold,
                                      bit a, bit c, bit r);
    exp_t e;
    int   cnt;
    int   dw;
    bit   m;
    if (r) begin
      m_prev[id] = 0; m_matches[id] = 0; m_run[id] = 0;
      m_since[id] = -1; m_rise[id] = 0;
    end else if (c) begin
      m_prev[id] = int'(a); m_matches[id] = 0; m_run[id] = 0;
      m_since[id] = -1; m_rise[id] = 0;
    end else begin
      m = a && (m_prev[id] == 0);
      m_prev[id] = int'(a);
      m_rise[id] = int'(m);
      if (m_since[id] >= 0) m_since[id]++;
      if (m) begin
        m_matches[id]++;
        if (m_matches[id] == thr) m_since[id] = 0;
      end
      m_run[id] = a ? m_run[id] + 1 : 0;
    end
    cnt = (m_matches[id] > maxv) ? maxv : m_matches[id];
    dw  = (m_run[id] > maxv) ? maxv : m_run[id];
    e.rise   = (m_rise[id] != 0);
    e.count  = 8'(cnt);
    e.sat    = (cnt == maxv);
    e.dwell  = 8'(dw);
    e.alarm  = (m_since[id] >= 0) && (m_since[id] < hold);
    e.locked = (m_since[id] >= hold);
    return e;
  endfunction

  task automatic step(bit a, bit c, bit r);
    @(negedge clk);
    ans   = a;
    clr   = c;
    reset = r;
    qa.push_back(model_step(0, 255, 4, 3, a, c, r));
    qb.push_back(model_step(1, 7, 4, 1, a, c, r));
  endtask

  task automatic compare(string name, exp_t act, exp_t e);
    tests++;
    if (act !== e) begin
      fails++;
      $display("FAIL %s cyc=%0d actual rise=%0b count=%0d sat=%0b dwell=%0d alarm=%0b locked=%0b required rise=%0b count=%0d sat=%0b dwell=%0d alarm=%0b locked=%0b",
               name, cyc, act.rise, act.count, act.sat, act.dwell, act.alarm, act.locked,
               e.rise, e.count, e.sat, e.dwell, e.alarm, e.locked);
    end
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per edge.
  initial begin
    exp_t act;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      act = {bus_a.rise, bus_a.count, bus_a.sat, bus_a.dwell, bus_a.alarm, bus_a.locked};
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut_a_queue cyc=%0d actual empty required entry", cyc);
      end else begin
        compare("dut_a", act, qa.pop_front());
      end
      act = {bus_b.rise, 5'b00000, bus_b.count, bus_b.sat, 5'b00000, bus_b.dwell,
             bus_b.alarm, bus_b.locked};
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut_b_queue cyc=%0d actual empty required entry", cyc);
      end else begin
        compare("dut_b", act, qb.pop_front());
      end
    end
  end

  initial begin
    int p;
    tests = 0;
    fails = 0;
    ans   = 1'b0;
    clr   = 1'b0;
    reset = 1'b1;

    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    // three isolated pulses, then a fourth reaching the threshold, then a fifth
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    // long high run from a fresh reset
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    // nine pulses to saturate the narrow instance, then a nine-cycle high run
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // clear coinciding with a match at count 2, flag stays high afterwards
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    // clear in the second alarm cycle
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    // count to 5, reset with flag high, match on first edge after reset
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // randomized segments with varying flag density
    p = 50;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 20) == 0) begin
        case ($urandom_range(0, 3))
          0: p = 10;
          1: p = 50;
          2: p = 90;
          default: p = 100;
        endcase
      end
      step($urandom_range(0, 99) < p,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) < 2);
    end
    step(1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL drain actual qa=%0d qb=%0d required 0 0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
